// File: rtl/link_control_fsm_pkg.sv
// Shared link-layer definitions: USB PID codes, controller state encoding and
// PID classification helpers.
package link_pkg;

  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TX_TOKEN  = 3'd1,
    ST_TX_DATA   = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_WAIT_HS   = 3'd4,
    ST_TX_HS     = 3'd5
  } link_state_e;

  function automatic logic pid_is_data(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

  function automatic logic pid_is_hs(input logic [3:0] pid);
    return (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
  endfunction

endpackage

// File: rtl/link_control_fsm_if.sv
// Packet-level handshake between the link controller (master) and the
// token analyser / tx packet builder / phy side (slave).
interface link_control_fsm_if;
  logic [3:0] rx_pid;
  logic       rx_pid_en;
  logic       rx_eop;
  logic       tx_lp_sop_en;
  logic       tx_lp_eop_en;
  logic       tx_data_on;
  logic       crc5_en;
  logic       rx_handshake_on;
  logic       d_oe;

  modport master (
    input  rx_pid, rx_pid_en, rx_eop, tx_lp_sop_en, tx_lp_eop_en,
    output tx_data_on, crc5_en, rx_handshake_on, d_oe
  );

  modport slave (
    output rx_pid, rx_pid_en, rx_eop, tx_lp_sop_en, tx_lp_eop_en,
    input  tx_data_on, crc5_en, rx_handshake_on, d_oe
  );
endinterface

// File: rtl/link_control_fsm_doe_turnaround.sv
// Phy output-enable control: raised on tx start, held for delay_threshold
// cycles after tx end so the bus turnaround stays driven.
module doe_turnaround #(
  parameter int unsigned DOE_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sop,
  input  logic             eop,
  input  logic [DOE_W-1:0] delay_threshold,
  output logic             d_oe
);

  logic             d_oe_q, d_oe_d;
  logic             hold_q, hold_d;
  logic [DOE_W-1:0] cnt_q, cnt_d;

  // Set/hold sequencing; a new sop always wins and cancels a pending drop.
  always_comb begin
    d_oe_d = d_oe_q;
    hold_d = hold_q;
    cnt_d  = cnt_q;
    if (sop) begin
      d_oe_d = 1'b1;
      hold_d = 1'b0;
      cnt_d  = '0;
    end else if (eop) begin
      if (delay_threshold == '0) begin
        d_oe_d = 1'b0;
        hold_d = 1'b0;
        cnt_d  = '0;
      end else begin
        // The eop cycle itself is hold cycle zero, so counting starts at 1.
        hold_d = 1'b1;
        cnt_d  = DOE_W'(1);
      end
    end else if (hold_q) begin
      if (cnt_q >= delay_threshold) begin
        d_oe_d = 1'b0;
        hold_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Turnaround state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_oe_q <= 1'b0;
      hold_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      d_oe_q <= d_oe_d;
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end

  assign d_oe = d_oe_q;

endmodule

// File: rtl/link_control_fsm.sv
// Link-layer controller: sequences token/data/handshake phases for host and
// device roles, with response timeout, bounded host retry and d_oe turnaround.
module link_control_fsm
  import link_pkg::*;
#(
  parameter int unsigned TO_W    = 16,
  parameter int unsigned DOE_W   = 6,
  parameter int unsigned RETRY_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TO_W-1:0]    time_threshold,
  input  logic [DOE_W-1:0]   delay_threshold,
  input  logic [RETRY_W-1:0] max_retry,
  input  logic               host_dir_out,
  input  logic               ms,
  link_control_fsm_if.master lnk,
  output logic               time_out,
  output logic               retry_req,
  output logic               xfer_done,
  output logic               xfer_fail,
  output logic [2:0]         state_o
);

  link_state_e        state_q, state_d;
  logic               role_q, role_d;
  logic [TO_W-1:0]    timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic time_out_q, time_out_d, retry_req_q, retry_req_d;
  logic xfer_done_q, xfer_done_d, xfer_fail_q, xfer_fail_d;
  logic tx_data_on_q, tx_data_on_d, crc5_en_q, crc5_en_d, rx_hs_on_q, rx_hs_on_d;

  logic host, tok_rx, data_rx, hs_rx, wait_st, expired;

  // Role is live in IDLE and frozen for the rest of the transfer.
  assign host    = (state_q == ST_IDLE) ? ms : role_q;
  assign tok_rx  = lnk.rx_pid_en && lnk.rx_eop;
  assign data_rx = tok_rx && pid_is_data(lnk.rx_pid);
  assign hs_rx   = lnk.rx_pid_en && pid_is_hs(lnk.rx_pid);
  assign wait_st = (state_q == ST_WAIT_DATA) || (state_q == ST_WAIT_HS);
  assign expired = wait_st && (timer_q == time_threshold);

  // Next-state, timer, retry and pulse logic; a valid PID in the expiry cycle beats the timeout.
  always_comb begin
    state_d     = state_q;
    role_d      = host;
    retry_d     = retry_q;
    time_out_d  = 1'b0;
    retry_req_d = 1'b0;
    xfer_done_d = 1'b0;
    xfer_fail_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ms) begin
          if (lnk.tx_lp_sop_en) state_d = ST_TX_TOKEN;
        end else if (tok_rx && (lnk.rx_pid == PID_IN)) begin
          state_d = ST_TX_DATA;
        end else if (tok_rx && ((lnk.rx_pid == PID_OUT) || (lnk.rx_pid == PID_SETUP))) begin
          state_d = ST_WAIT_DATA;
        end
      end
      ST_TX_TOKEN: if (lnk.tx_lp_eop_en) state_d = host_dir_out ? ST_TX_DATA : ST_WAIT_DATA;
      ST_TX_DATA:  if (lnk.tx_lp_eop_en) state_d = ST_WAIT_HS;
      ST_WAIT_DATA: begin
        if (data_rx) begin
          state_d = ST_TX_HS;
        end else if (host && hs_rx && (lnk.rx_pid != PID_ACK)) begin
          state_d     = ST_IDLE;
          xfer_done_d = 1'b1;
        end else if (expired) begin
          state_d    = ST_IDLE;
          time_out_d = 1'b1;
        end
      end
      ST_WAIT_HS: begin
        if (hs_rx) begin
          state_d     = ST_IDLE;
          xfer_done_d = 1'b1;
        end else if (expired) begin
          state_d    = ST_IDLE;
          time_out_d = 1'b1;
        end
      end
      ST_TX_HS: begin
        if (lnk.tx_lp_eop_en) begin
          state_d     = ST_IDLE;
          xfer_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (time_out_d && host) begin
      if (retry_q < max_retry) begin
        retry_d     = retry_q + 1'b1;
        retry_req_d = 1'b1;
      end else begin
        retry_d     = '0;
        xfer_fail_d = 1'b1;
      end
    end
    if (xfer_done_d) retry_d = '0;

    // Timer restarts from zero on any wait-state entry and saturates.
    if ((state_d == state_q) && wait_st) timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    else                                 timer_d = '0;

    tx_data_on_d = (state_d == ST_TX_DATA);
    crc5_en_d    = (state_d == ST_TX_TOKEN);
    rx_hs_on_d   = (state_d == ST_WAIT_HS);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      role_q       <= 1'b0;
      timer_q      <= '0;
      retry_q      <= '0;
      time_out_q   <= 1'b0;
      retry_req_q  <= 1'b0;
      xfer_done_q  <= 1'b0;
      xfer_fail_q  <= 1'b0;
      tx_data_on_q <= 1'b0;
      crc5_en_q    <= 1'b0;
      rx_hs_on_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      role_q       <= role_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      time_out_q   <= time_out_d;
      retry_req_q  <= retry_req_d;
      xfer_done_q  <= xfer_done_d;
      xfer_fail_q  <= xfer_fail_d;
      tx_data_on_q <= tx_data_on_d;
      crc5_en_q    <= crc5_en_d;
      rx_hs_on_q   <= rx_hs_on_d;
    end
  end

  doe_turnaround #(.DOE_W(DOE_W)) u_doe (
    .clk             (clk),
    .rst             (rst),
    .sop             (lnk.tx_lp_sop_en),
    .eop             (lnk.tx_lp_eop_en),
    .delay_threshold (delay_threshold),
    .d_oe            (lnk.d_oe)
  );

  assign lnk.tx_data_on      = tx_data_on_q;
  assign lnk.crc5_en         = crc5_en_q;
  assign lnk.rx_handshake_on = rx_hs_on_q;
  assign time_out            = time_out_q;
  assign retry_req           = retry_req_q;
  assign xfer_done           = xfer_done_q;
  assign xfer_fail           = xfer_fail_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_link_control_fsm.sv
// Directed bench for link_control_fsm: completion/timeout pulses go through a
// scoreboard queue; timing-specific behaviour is checked inline.
module tb_link_control_fsm;
  import link_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] time_threshold;
  logic [5:0]  delay_threshold;
  logic [1:0]  max_retry;
  logic        host_dir_out, ms;
  logic        time_out, retry_req, xfer_done, xfer_fail;
  logic [2:0]  state_o;

  link_control_fsm_if lif ();

  link_control_fsm #(.TO_W(16), .DOE_W(6), .RETRY_W(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .time_threshold  (time_threshold),
    .delay_threshold (delay_threshold),
    .max_retry       (max_retry),
    .host_dir_out    (host_dir_out),
    .ms              (ms),
    .lnk             (lif),
    .time_out        (time_out),
    .retry_req       (retry_req),
    .xfer_done       (xfer_done),
    .xfer_fail       (xfer_fail),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic done; logic fail; logic to; logic rr;} ev_t;
  ev_t exp_q[$];
  ev_t mon_act, mon_exp;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic d, input logic f, input logic t, input logic r);
    exp_q.push_back({d, f, t, r});
  endtask

  // Scoreboard monitor: every completion/timeout pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && (xfer_done || xfer_fail || time_out || retry_req)) begin
      mon_act = {xfer_done, xfer_fail, time_out, retry_req};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL event_unexpected: got %b expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("event", {25'd0, mon_act, state_o}, {25'd0, mon_exp, 3'd0});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sop();
    lif.tx_lp_sop_en = 1'b1;
    cyc();
    lif.tx_lp_sop_en = 1'b0;
  endtask

  task automatic eop();
    lif.tx_lp_eop_en = 1'b1;
    cyc();
    lif.tx_lp_eop_en = 1'b0;
  endtask

  task automatic rx(input logic [3:0] pid, input logic with_eop);
    lif.rx_pid    = pid;
    lif.rx_pid_en = 1'b1;
    lif.rx_eop    = with_eop;
    cyc();
    lif.rx_pid    = 4'b0000;
    lif.rx_pid_en = 1'b0;
    lif.rx_eop    = 1'b0;
  endtask

  // Host OUT up to the handshake wait; returns in wait cycle 0.
  task automatic host_out_to_hs();
    ms = 1'b1;
    host_dir_out = 1'b1;
    sop();
    chk("host_crc5_en", lif.crc5_en, 1);
    eop();
    chk("host_tx_data_on", lif.tx_data_on, 1);
    sop();
    eop();
    chk("host_rx_hs_on", lif.rx_handshake_on, 1);
  endtask

  task automatic outputs_zero(input string name);
    chk(name, {21'd0, lif.tx_data_on, lif.crc5_en, lif.rx_handshake_on, lif.d_oe,
               time_out, retry_req, xfer_done, xfer_fail, state_o}, 0);
  endtask

  int n;
  logic seen;

  initial begin
    lif.rx_pid = 4'b0000; lif.rx_pid_en = 1'b0; lif.rx_eop = 1'b0;
    lif.tx_lp_sop_en = 1'b0; lif.tx_lp_eop_en = 1'b0;
    time_threshold = 16'd20; delay_threshold = 6'd2; max_retry = 2'd2;
    host_dir_out = 1'b0; ms = 1'b0;

    repeat (2) @(negedge clk);
    outputs_zero("reset_outputs");
    @(posedge clk); #1 rst = 1'b1;
    cyc();

    // Device IN, ACK in wait cycle 5 of 20.
    rx(PID_IN, 1'b1);
    chk("dev_in_state", state_o, ST_TX_DATA);
    chk("dev_in_tx_data_on", lif.tx_data_on, 1);
    sop();
    chk("dev_in_d_oe", lif.d_oe, 1);
    eop();
    chk("dev_in_wait_hs", state_o, ST_WAIT_HS);
    repeat (5) cyc();
    expect_ev(1, 0, 0, 0);
    rx(PID_ACK, 1'b0);
    repeat (3) cyc();

    // Host OUT timeout latency with threshold 10: 11 wait cycles, then the pulse.
    time_threshold = 16'd10;
    expect_ev(0, 0, 1, 1);
    host_out_to_hs();
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (time_out) seen = 1'b1;
      else if (state_o == ST_WAIT_HS) n++;
    end
    chk("to_seen", seen, 1);
    chk("to_wait_cycles", n, 11);
    cyc();

    // Second retry, then exhaustion, then counter restarted.
    expect_ev(0, 0, 1, 1);
    host_out_to_hs(); repeat (14) cyc();
    expect_ev(0, 1, 1, 0);
    host_out_to_hs(); repeat (14) cyc();
    expect_ev(0, 0, 1, 1);
    host_out_to_hs(); repeat (14) cyc();

    // ACK exactly when timer == threshold: done wins, and it clears the retry count.
    time_threshold = 16'd6;
    host_out_to_hs();
    repeat (6) cyc();
    expect_ev(1, 0, 0, 0);
    rx(PID_ACK, 1'b0);
    repeat (2) cyc();
    expect_ev(0, 0, 1, 1);
    host_out_to_hs(); repeat (10) cyc();
    expect_ev(0, 0, 1, 1);
    host_out_to_hs(); repeat (10) cyc();
    expect_ev(0, 1, 1, 0);
    host_out_to_hs(); repeat (10) cyc();

    // Host IN with data, then host IN answered by NAK.
    time_threshold = 16'd20;
    host_dir_out = 1'b0;
    sop(); eop();
    chk("host_in_wait_data", state_o, ST_WAIT_DATA);
    rx(PID_DATA1, 1'b1);
    chk("host_in_tx_hs", state_o, ST_TX_HS);
    sop();
    expect_ev(1, 0, 0, 0);
    eop();
    repeat (2) cyc();
    sop(); eop();
    expect_ev(1, 0, 0, 0);
    rx(PID_NAK, 1'b1);
    repeat (2) cyc();

    // Device OUT; role flip to host mid-transfer must not make NAK end it.
    ms = 1'b0;
    rx(PID_OUT, 1'b1);
    chk("dev_out_wait_data", state_o, ST_WAIT_DATA);
    ms = 1'b1;
    rx(PID_NAK, 1'b1);
    chk("dev_ms_ignored", state_o, ST_WAIT_DATA);
    rx(PID_DATA0, 1'b1);
    chk("dev_out_tx_hs", state_o, ST_TX_HS);
    sop();
    expect_ev(1, 0, 0, 0);
    eop();
    ms = 1'b0;
    repeat (2) cyc();

    // Device IN with threshold 0: timeout on first wait cycle, no retry/fail; stray DATA ignored.
    rx(PID_IN, 1'b1);
    rx(PID_DATA0, 1'b1);
    chk("dev_stray_pid", state_o, ST_TX_DATA);
    sop();
    time_threshold = 16'd0;
    expect_ev(0, 0, 1, 0);
    eop();
    cyc();
    chk("dev_to_idle", state_o, ST_IDLE);
    repeat (2) cyc();
    time_threshold = 16'd20;

    // d_oe hold of 4 after eop: high for 4 cycles, low in the 5th.
    delay_threshold = 6'd4;
    sop(); cyc(); eop();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("doe_hold4_c%0d", i), lif.d_oe, (i < 5) ? 1 : 0);
    end
    cyc();

    // d_oe hold of 0: drops the cycle after eop.
    delay_threshold = 6'd0;
    sop();
    chk("doe_set", lif.d_oe, 1);
    eop();
    @(negedge clk);
    chk("doe_hold0", lif.d_oe, 0);
    cyc();

    // New sop during hold keeps d_oe high.
    delay_threshold = 6'd4;
    sop(); eop(); cyc(); sop();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (lif.d_oe) n++;
    end
    chk("doe_restart", n, 8);
    cyc();
    eop();
    repeat (6) cyc();
    chk("doe_after_restart", lif.d_oe, 0);

    // Async reset in TX_DATA clears everything immediately; next IN works.
    delay_threshold = 6'd2;
    rx(PID_IN, 1'b1);
    sop();
    chk("pre_reset_busy", {lif.tx_data_on, lif.d_oe, state_o}, {2'b11, ST_TX_DATA});
    rst = 1'b0;
    #1;
    outputs_zero("async_reset");
    cyc();
    rst = 1'b1;
    cyc();
    rx(PID_IN, 1'b1);
    chk("post_reset_in", state_o, ST_TX_DATA);
    sop(); eop();
    expect_ev(1, 0, 0, 0);
    rx(PID_ACK, 1'b0);

    repeat (5) cyc();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
